// File: rtl/polling_ltssm_if.sv
// Handshake bundle between the phy2mac receive driver and the polling LTSSM
// sequencer. The driver side (master) supplies OS-boundary and partner-OS
// pulses. The sequencer (slave) returns the state and the OS length to replay.
interface polling_ltssm_if;
  logic        en_n;
  logic        rx_present;
  logic        finished_os;
  logic        rx_ts1_seen;
  logic        rx_ts2_seen;
  logic [2:0]  ltssm_state;
  logic [5:0]  seq_ptr_max;
  logic        link_up;
  logic        timeout;
  logic [15:0] tx_os_cnt;

  modport master (
    output en_n, rx_present, finished_os, rx_ts1_seen, rx_ts2_seen,
    input  ltssm_state, seq_ptr_max, link_up, timeout, tx_os_cnt
  );

  modport slave (
    input  en_n, rx_present, finished_os, rx_ts1_seen, rx_ts2_seen,
    output ltssm_state, seq_ptr_max, link_up, timeout, tx_os_cnt
  );
endinterface

// File: rtl/polling_ltssm_ctrl.sv
// Local LTSSM sequencer for the phy2mac receive driver. It walks the states
// DETECT_QUIET -> POLLING_ACTIVE -> START_TS1 -> POLLING_CONFIG -> LINK_READY.
// It advances only on finished_os boundaries, so the driver's sequence
// pointer is always at a wrapped position when the OS length changes.
module polling_ltssm_ctrl #(
  parameter int QUIET_CYC   = 16,
  parameter int SKP_LEN     = 4,
  parameter int TS_LEN      = 16,
  parameter int SKP_BURST   = 2,
  parameter int TS1_TX_MIN  = 64,
  parameter int TS2_TX_MIN  = 16,
  parameter int RX_TS_MIN   = 8,
  parameter int TIMEOUT_CYC = 24000
) (
  input  logic             clk,
  input  logic             p2md_rstn,
  polling_ltssm_if.slave   bus
);

  typedef enum logic [2:0] {
    DETECT_QUIET             = 3'd0,
    POLLING_ACTIVE           = 3'd1,
    POLLING_ACTIVE_START_TS1 = 3'd2,
    POLLING_CONFIG           = 3'd3,
    LINK_READY               = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] tx_q, tx_d, rx_q, rx_d;
  logic [23:0] timer_q, timer_d;
  logic        timeout_pend, timeout_pend_d;
  logic [5:0]  seq_q, seq_d;
  logic        link_q, link_d, to_q, to_d;

  logic [15:0] tx_inc, rx_inc, tx_min;
  logic        rx_hit, exit_ok;

  // State and all outputs register together, so state and OS length never skew.
  always_ff @(posedge clk or negedge p2md_rstn) begin
    if (!p2md_rstn) begin
      state_q      <= DETECT_QUIET;
      tx_q         <= '0;
      rx_q         <= '0;
      timer_q      <= '0;
      timeout_pend <= 1'b0;
      seq_q        <= '0;
      link_q       <= 1'b0;
      to_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      timer_q      <= timer_d;
      timeout_pend <= timeout_pend_d;
      seq_q        <= seq_d;
      link_q       <= link_d;
      to_q         <= to_d;
    end
  end

  // Next state, counters and next registered outputs.
  always_comb begin
    state_d        = state_q;
    tx_d           = tx_q;
    rx_d           = rx_q;
    timer_d        = (timer_q == 24'hFF_FFFF) ? timer_q : timer_q + 24'd1;
    timeout_pend_d = timeout_pend;
    to_d           = 1'b0;

    tx_inc = (tx_q == 16'hFFFF) ? tx_q : tx_q + 16'd1;
    rx_hit = 1'b0;
    tx_min = 16'(TS1_TX_MIN);
    if (state_q == POLLING_ACTIVE_START_TS1) begin
      rx_hit = bus.rx_ts1_seen | bus.rx_ts2_seen;
    end else if (state_q == POLLING_CONFIG) begin
      rx_hit = bus.rx_ts2_seen;
      tx_min = 16'(TS2_TX_MIN);
    end
    rx_inc  = (rx_hit && rx_q != 16'hFFFF) ? rx_q + 16'd1 : rx_q;
    // The exit check uses post-increment counts, including a same-cycle rx pulse.
    exit_ok = (tx_inc >= tx_min) && (rx_inc >= 16'(RX_TS_MIN));

    case (state_q)
      DETECT_QUIET: begin
        if (timer_q >= 24'(QUIET_CYC - 1) && bus.rx_present)
          state_d = POLLING_ACTIVE;
      end
      POLLING_ACTIVE: begin
        if (bus.finished_os) begin
          tx_d = tx_inc;
          if (tx_inc >= 16'(SKP_BURST)) state_d = POLLING_ACTIVE_START_TS1;
        end
      end
      POLLING_ACTIVE_START_TS1, POLLING_CONFIG: begin
        rx_d = rx_inc;
        if (timer_q == 24'(TIMEOUT_CYC - 1)) timeout_pend_d = 1'b1;
        // A pending timeout is held until the OS boundary; a met exit wins.
        if (bus.finished_os) begin
          tx_d = tx_inc;
          if (exit_ok) begin
            state_d = (state_q == POLLING_CONFIG) ? LINK_READY : POLLING_CONFIG;
          end else if (timeout_pend) begin
            state_d = DETECT_QUIET;
            to_d    = 1'b1;
          end
        end
      end
      LINK_READY: ;
      default: state_d = DETECT_QUIET;
    endcase

    if (state_d != state_q) begin
      tx_d           = '0;
      rx_d           = '0;
      timer_d        = '0;
      timeout_pend_d = 1'b0;
    end

    case (state_d)
      POLLING_ACTIVE:                          seq_d = 6'(SKP_LEN);
      POLLING_ACTIVE_START_TS1, POLLING_CONFIG: seq_d = 6'(TS_LEN);
      default:                                 seq_d = '0;
    endcase
    link_d = (state_d == LINK_READY);

    // A synchronous disable looks exactly like reset.
    if (bus.en_n) begin
      state_d        = DETECT_QUIET;
      tx_d           = '0;
      rx_d           = '0;
      timer_d        = '0;
      timeout_pend_d = 1'b0;
      seq_d          = '0;
      link_d         = 1'b0;
      to_d           = 1'b0;
    end
  end

  assign bus.ltssm_state = state_q;
  assign bus.seq_ptr_max = seq_q;
  assign bus.link_up     = link_q;
  assign bus.timeout     = to_q;
  assign bus.tx_os_cnt   = tx_q;

endmodule

// File: tb/tb_polling_ltssm_ctrl.sv
// Directed bench for polling_ltssm_ctrl using default parameters.
module tb_polling_ltssm_ctrl;
  logic clk = 1'b0;
  logic p2md_rstn = 1'b1;
  int   checks = 0;
  int   failures = 0;

  polling_ltssm_if bus();

  polling_ltssm_ctrl dut (
    .clk       (clk),
    .p2md_rstn (p2md_rstn),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic fin, input logic t1, input logic t2);
    bus.finished_os = fin;
    bus.rx_ts1_seen = t1;
    bus.rx_ts2_seen = t2;
    tick(1);
    bus.finished_os = 1'b0;
    bus.rx_ts1_seen = 1'b0;
    bus.rx_ts2_seen = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int st, input int seq, input int lu,
                         input int to, input int tx);
    chk({tag, ".state"}, 32'(bus.ltssm_state), 32'(st));
    chk({tag, ".seq"},   32'(bus.seq_ptr_max), 32'(seq));
    chk({tag, ".link"},  32'(bus.link_up),     32'(lu));
    chk({tag, ".to"},    32'(bus.timeout),     32'(to));
    chk({tag, ".tx"},    32'(bus.tx_os_cnt),   32'(tx));
  endtask

  task automatic do_reset();
    bus.en_n        = 1'b0;
    bus.rx_present  = 1'b0;
    bus.finished_os = 1'b0;
    bus.rx_ts1_seen = 1'b0;
    bus.rx_ts2_seen = 1'b0;
    p2md_rstn = 1'b1;
    #1 p2md_rstn = 1'b0;
    #1 chk_out("rst", 0, 0, 0, 0, 0);
    tick(1);
    p2md_rstn = 1'b1;
  endtask

  task automatic to_ts1();
    do_reset();
    bus.rx_present = 1'b1;
    tick(16);
    chk_out("pa_entry", 1, 4, 0, 0, 0);
    tick(3);
    drive(1, 0, 0);
    tick(3);
    drive(1, 0, 0);
    chk_out("ts1_entry", 2, 16, 0, 0, 0);
  endtask

  initial begin
    // Quiet with no receiver: hold, then leave as soon as one is present.
    do_reset();
    tick(30);
    chk("dq_norx.state", 32'(bus.ltssm_state), 0);
    bus.rx_present = 1'b1;
    tick(1);
    chk("dq_late_rx.state", 32'(bus.ltssm_state), 1);

    // Full walk to LINK_READY.
    do_reset();
    bus.rx_present = 1'b1;
    tick(15);
    chk("dq_15.state", 32'(bus.ltssm_state), 0);
    tick(1);
    chk_out("pa", 1, 4, 0, 0, 0);
    tick(3);
    drive(1, 0, 0);
    chk_out("pa_skp1", 1, 4, 0, 0, 1);
    tick(3);
    drive(1, 0, 0);
    chk_out("ts1", 2, 16, 0, 0, 0);
    for (int i = 1; i <= 63; i++) begin
      drive(0, i <= 8, 0);
      tick(14);
      drive(1, 0, 0);
    end
    chk_out("ts1_63", 2, 16, 0, 0, 63);
    tick(15);
    drive(1, 0, 0);
    chk_out("cfg", 3, 16, 0, 0, 0);
    // TS1 pulses are not counted in POLLING_CONFIG; only 7 TS2 before 16 sent.
    for (int i = 1; i <= 16; i++) begin
      drive(0, 1, i <= 7);
      tick(14);
      drive(1, 0, 0);
    end
    chk_out("cfg_rx7", 3, 16, 0, 0, 16);
    drive(0, 0, 1);
    tick(14);
    drive(1, 0, 0);
    chk_out("lr", 4, 0, 1, 0, 0);
    drive(1, 0, 0);
    chk_out("lr_fin", 4, 0, 1, 0, 0);
    bus.en_n = 1'b1;
    tick(1);
    bus.en_n = 1'b0;
    chk_out("en_n", 0, 0, 0, 0, 0);
    tick(1);
    chk("en_n_rel.state", 32'(bus.ltssm_state), 0);

    // The 8th rx pulse coincides with the 64th finished_os.
    to_ts1();
    for (int i = 0; i < 7; i++) drive(0, 1, 0);
    for (int i = 0; i < 63; i++) drive(1, 0, 0);
    chk_out("co_pre", 2, 16, 0, 0, 63);
    drive(1, 1, 0);
    chk_out("co_exit", 3, 16, 0, 0, 0);
    drive(1, 0, 0);
    chk("cfg_tx1", 32'(bus.tx_os_cnt), 1);
    // Asynchronous reset between clock edges.
    #3 p2md_rstn = 1'b0;
    #1 chk_out("async_rst", 0, 0, 0, 0, 0);
    tick(1);
    p2md_rstn = 1'b1;

    // Timeout with no partner TS: pend at 24000 cycles, exit on the next OS boundary.
    to_ts1();
    tick(23999);
    chk("to_pend_pre", 32'(dut.timeout_pend), 0);
    tick(1);
    chk("to_pend_set", 32'(dut.timeout_pend), 1);
    tick(5);
    chk_out("to_hold", 2, 16, 0, 0, 0);
    drive(1, 0, 0);
    chk_out("to_exit", 0, 0, 0, 1, 0);
    tick(1);
    chk("to_pulse_end", 32'(bus.timeout), 0);

    // Timeout pending, but criteria met on the same finished_os: exit wins.
    to_ts1();
    for (int i = 0; i < 64; i++) drive(1, 0, 0);
    chk_out("tw_tx64", 2, 16, 0, 0, 64);
    for (int i = 0; i < 7; i++) drive(0, 1, 0);
    tick(24000);
    chk("tw_pend", 32'(dut.timeout_pend), 1);
    drive(1, 1, 0);
    chk_out("tw_exit", 3, 16, 0, 0, 0);
    tick(1);
    chk("tw_no_to", 32'(bus.timeout), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
